// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
//   core_id_t   : identifies which fetch stage owns a grant or response
//   fetch_req_t : one core's fetch request bundle (request, address, flush)
//   IMEM_RD_LATENCY : cycles from mem_en sampled to mem_rdata valid
package imem_arb_pkg;

  localparam int IMEM_ADDR_W     = 32;
  localparam int IMEM_RD_LATENCY = 1;

  typedef enum logic {
    CORE0 = 1'b0,
    CORE1 = 1'b1
  } core_id_t;

  typedef struct packed {
    logic                   req;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   flush;
  } fetch_req_t;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Bus bundle between the two IF stages, the arbiter and the shared IMEM.
//   reqN/addrN/flushN : core N fetch request, address, redirect
//   gntN              : core N request accepted this cycle
//   rvalidN/rdataN    : core N instruction response
//   mem_en/mem_addr   : IMEM read strobe and address
//   mem_rdata         : IMEM read data, one cycle after mem_en
// Modports: slave = arbiter side, master = cores/memory side.
interface imem_fetch_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              flush0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              flush1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, addr0, flush0, req1, addr1, flush1, mem_rdata,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_en, mem_addr
  );

  modport master (
    output req0, addr0, flush0, req1, addr1, flush1, mem_rdata,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, mem_en, mem_addr
  );
endinterface

// File: rtl/imem_fetch_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   req0, req1 : effective (already flush/reset qualified) requests
//   gnt0, gnt1 : one-hot-or-zero grants, combinational in the request cycle
// rr_last remembers the most recent winner; on a conflict the other core wins.
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  core_id_t rr_last;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (rr_last == CORE1) gnt0 = 1'b1;
      else                  gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Reset to CORE1 so core 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst)       rr_last <= CORE1;
    else if (gnt0) rr_last <= CORE0;
    else if (gnt1) rr_last <= CORE1;
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one synchronous-read IMEM between two fetch stages.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : core request/grant/response and IMEM signals
//   gnt_cnt0/1    : saturating grant counts per core
//   conflict_cnt  : saturating count of cycles where both cores requested
// Responses return one cycle after the grant to the recorded owner and are
// dropped if that core flushes in the response cycle (no retry).
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_fetch_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic     eff_req0, eff_req1;
  logic     pending_vld_p1;
  core_id_t pending_owner_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign eff_req0 = bus.req0 & ~bus.flush0 & ~rst;
  assign eff_req1 = bus.req1 & ~bus.flush1 & ~rst;

  rr_arbiter2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (eff_req0),
    .req1 (eff_req1),
    .gnt0 (bus.gnt0),
    .gnt1 (bus.gnt1)
  );

  // Stage p0: grant cycle drives the memory directly.
  assign bus.mem_en   = bus.gnt0 | bus.gnt1;
  assign bus.mem_addr = bus.gnt0 ? bus.addr0 :
                        bus.gnt1 ? bus.addr1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_vld_p1   <= 1'b0;
      pending_owner_p1 <= CORE0;
      gnt_cnt0         <= '0;
      gnt_cnt1         <= '0;
      conflict_cnt     <= '0;
    end else begin
      pending_vld_p1   <= bus.gnt0 | bus.gnt1;
      pending_owner_p1 <= bus.gnt1 ? CORE1 : CORE0;
      if (bus.gnt0)            gnt_cnt0     <= sat_inc(gnt_cnt0);
      if (bus.gnt1)            gnt_cnt1     <= sat_inc(gnt_cnt1);
      if (eff_req0 && eff_req1) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  // Stage p1: memory data arrives; route to owner unless that core flushed.
  assign bus.rvalid0 = pending_vld_p1 & (pending_owner_p1 == CORE0) & ~bus.flush0 & ~rst;
  assign bus.rvalid1 = pending_vld_p1 & (pending_owner_p1 == CORE1) & ~bus.flush1 & ~rst;
  assign bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;

  a_one_gnt:    assert property (@(posedge clk) disable iff (rst) !(bus.gnt0 && bus.gnt1));
  a_one_rvalid: assert property (@(posedge clk) disable iff (rst) !(bus.rvalid0 && bus.rvalid1));
  a_no_gnt_fl0: assert property (@(posedge clk) disable iff (rst) !(bus.gnt0 && bus.flush0));
  a_no_gnt_fl1: assert property (@(posedge clk) disable iff (rst) !(bus.gnt1 && bus.flush1));
  a_align0:     assert property (@(posedge clk) disable iff (rst) bus.gnt0 |-> (bus.addr0[1:0] == 2'b00));
  a_align1:     assert property (@(posedge clk) disable iff (rst) bus.gnt1 |-> (bus.addr1[1:0] == 2'b00));

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rst_s;
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
  logic [1:0]  gnt_cnt0_s, gnt_cnt1_s, conflict_cnt_s;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  imem_fetch_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sbus ();

  imem_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .gnt_cnt0     (gnt_cnt0),
    .gnt_cnt1     (gnt_cnt1),
    .conflict_cnt (conflict_cnt)
  );

  // Narrow-counter instance to reach saturation in a few cycles.
  imem_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst_s),
    .bus          (sbus),
    .gnt_cnt0     (gnt_cnt0_s),
    .gnt_cnt1     (gnt_cnt1_s),
    .conflict_cnt (conflict_cnt_s)
  );

  // IMEM model: data is a fixed function of the address, one cycle late.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= 32'hC0DE_0000 ^ bus.mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.addr0 = '0; bus.flush0 = 1'b0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.flush1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    clear_inputs();
    bus.mem_rdata = '0;
    sbus.req0 = 1'b0; sbus.addr0 = '0; sbus.flush0 = 1'b0;
    sbus.req1 = 1'b0; sbus.addr1 = '0; sbus.flush1 = 1'b0;
    sbus.mem_rdata = '0;

    // Reset: a request during reset is ignored.
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    settle();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rdata0", bus.rdata0, 0);
    chk("rst_gnt_cnt0", gnt_cnt0, 0);
    chk("rst_conflict", conflict_cnt, 0);

    // Single requester.
    tick();
    rst = 1'b0; bus.req0 = 1'b1; bus.addr0 = 32'h10;
    settle();
    chk("t1_gnt0", bus.gnt0, 1);
    chk("t1_gnt1", bus.gnt1, 0);
    chk("t1_mem_en", bus.mem_en, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    tick();
    bus.req0 = 1'b0;
    settle();
    chk("t1_rvalid0", bus.rvalid0, 1);
    chk("t1_rdata0", bus.rdata0, 32'hC0DE_0010);
    chk("t1_rvalid1", bus.rvalid1, 0);
    chk("t1_gnt_cnt0", gnt_cnt0, 1);

    // Both request for 4 cycles: 0,1,0,1.
    tick();
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 32'h100;
    bus.req1 = 1'b1; bus.addr1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_gnt0_%0d", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("t2_gnt1_%0d", i), bus.gnt1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("t2_addr_%0d", i), bus.mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      if (i > 0) begin
        chk($sformatf("t2_rvalid0_%0d", i), bus.rvalid0, (i % 2 == 1) ? 1 : 0);
        chk($sformatf("t2_rvalid1_%0d", i), bus.rvalid1, (i % 2 == 0) ? 1 : 0);
      end
      tick();
    end
    clear_inputs();
    settle();
    chk("t2_rvalid1_last", bus.rvalid1, 1);
    chk("t2_rdata1_last", bus.rdata1, 32'hC0DE_0200);
    chk("t2_rvalid0_last", bus.rvalid0, 0);
    chk("t2_conflict", conflict_cnt, 4);
    chk("t2_gnt_cnt0", gnt_cnt0, 2);
    chk("t2_gnt_cnt1", gnt_cnt1, 2);

    // Core 1 response flushed; core 0 wins the flush cycle.
    tick();
    bus.req1 = 1'b1; bus.addr1 = 32'h40;
    settle();
    chk("t3_gnt1", bus.gnt1, 1);
    chk("t3_addr", bus.mem_addr, 32'h40);
    tick();
    bus.flush1 = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 32'h80;
    settle();
    chk("t3_fl_gnt1", bus.gnt1, 0);
    chk("t3_fl_gnt0", bus.gnt0, 1);
    chk("t3_fl_addr", bus.mem_addr, 32'h80);
    chk("t3_fl_rvalid1", bus.rvalid1, 0);
    chk("t3_fl_rdata1", bus.rdata1, 0);
    tick();
    clear_inputs();
    settle();
    chk("t3_rvalid0", bus.rvalid0, 1);
    chk("t3_rdata0", bus.rdata0, 32'hC0DE_0080);
    chk("t3_gnt_cnt0", gnt_cnt0, 3);
    chk("t3_gnt_cnt1", gnt_cnt1, 3);

    // Flush with request on core 0 while core 1 requests.
    tick();
    bus.req0 = 1'b1; bus.flush0 = 1'b1; bus.addr0 = 32'h84;
    bus.req1 = 1'b1; bus.addr1 = 32'h44;
    settle();
    chk("t4_gnt0", bus.gnt0, 0);
    chk("t4_gnt1", bus.gnt1, 1);
    chk("t4_addr", bus.mem_addr, 32'h44);
    tick();
    bus.flush0 = 1'b0; bus.addr0 = 32'h88;
    settle();
    chk("t4_rr_gnt0", bus.gnt0, 1);
    chk("t4_rr_gnt1", bus.gnt1, 0);
    chk("t4_rr_addr", bus.mem_addr, 32'h88);
    chk("t4_rvalid1", bus.rvalid1, 1);
    chk("t4_rdata1", bus.rdata1, 32'hC0DE_0044);
    tick();
    clear_inputs();
    settle();
    chk("t4_conflict", conflict_cnt, 5);
    chk("t4_rdata0", bus.rdata0, 32'hC0DE_0088);

    // Reset in the response cycle drops the pending response.
    tick();
    bus.req0 = 1'b1; bus.addr0 = 32'h10;
    settle();
    chk("t5_gnt0", bus.gnt0, 1);
    tick();
    bus.req0 = 1'b0; rst = 1'b1;
    tick();
    settle();
    chk("t5_rvalid0", bus.rvalid0, 0);
    chk("t5_rdata0", bus.rdata0, 0);
    chk("t5_mem_en", bus.mem_en, 0);
    chk("t5_gnt_cnt0", gnt_cnt0, 0);
    chk("t5_gnt_cnt1", gnt_cnt1, 0);
    chk("t5_conflict", conflict_cnt, 0);
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 32'h300;
    bus.req1 = 1'b1; bus.addr1 = 32'h400;
    settle();
    chk("t5_first_gnt0", bus.gnt0, 1);
    chk("t5_first_gnt1", bus.gnt1, 0);
    chk("t5_first_addr", bus.mem_addr, 32'h300);
    tick();
    clear_inputs();
    settle();
    chk("t5_rvalid0_after", bus.rvalid0, 1);
    chk("t5_conflict_after", conflict_cnt, 1);

    // Counter saturation on the 2-bit instance.
    tick();
    rst_s = 1'b0;
    sbus.req0 = 1'b1; sbus.req1 = 1'b1;
    repeat (3) tick();
    settle();
    chk("t6_conflict_3", conflict_cnt_s, 3);
    chk("t6_gnt0_3", gnt_cnt0_s, 2);
    chk("t6_gnt1_3", gnt_cnt1_s, 1);
    repeat (5) tick();
    settle();
    chk("t6_conflict_sat", conflict_cnt_s, 3);
    chk("t6_gnt0_sat", gnt_cnt0_s, 3);
    chk("t6_gnt1_sat", gnt_cnt1_s, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
